fp_cvt96_to128_arb: RTL and testbench

Round-robin scheduler that shares one 96-to-128-bit floating-point widening converter among NREQ requesters. It accepts one FP96 operand per grant and registers it. It then drives the operand through the shared combinational converter (fpCvt96To128) and holds the FP128 result, tagged with the requester index, until the consumer accepts it. It sits between the per-lane issue logic and the wide (quad) FP register writeback path.

---
 rtl/fp_cvt96_to128_arb_pkg.sv | 33 +++
 rtl/fp_cvt96_to128_arb_rr_arbiter.sv | 54 +++++
 rtl/fp_cvt96_to128_arb.sv | 93 +++++++++
 tb/tb_fp_cvt96_to128_arb.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_cvt96_to128_arb_pkg.sv
// FP96/FP128 operand formats shared by the widening converter and its scheduler.
// FP96 carries an 80-bit fraction; FP128 widens it to 112 bits, same exponent width.
package fp96Pkg;
  localparam int FP96_EXPW = 15;
  localparam int FP96_SIGW = 80;
  localparam logic [FP96_EXPW-1:0] FP96_BIAS    = 15'h3FFF;
  localparam logic [FP96_EXPW-1:0] FP96_EXP_MAX = 15'h7FFF;

  typedef struct packed {
    logic                 sign;
    logic [FP96_EXPW-1:0] exp;
    logic [FP96_SIGW-1:0] sig;
  } fp96_t;
endpackage

package fp128Pkg;
  localparam int FP128_EXPW = 15;
  localparam int FP128_SIGW = 112;
  localparam logic [FP128_EXPW-1:0] FP128_BIAS    = 15'h3FFF;
  localparam logic [FP128_EXPW-1:0] FP128_EXP_MAX = 15'h7FFF;

  typedef struct packed {
    logic                  sign;
    logic [FP128_EXPW-1:0] exp;
    logic [FP128_SIGW-1:0] sig;
  } fp128_t;

  typedef enum logic [1:0] {
    CVT_IDLE,
    CVT_CONV,
    CVT_HOLD
  } cvt_state_e;
endpackage

// File: rtl/fp_cvt96_to128_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant for the first requester after last_grant_i,
// wrapping mod NREQ. Purely combinational so it can front any shared FP unit.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int TAGW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [TAGW-1:0] last_grant_i,
  output logic [NREQ-1:0] grant_o,
  output logic [TAGW-1:0] grant_idx_o,
  output logic            any_o
);
  logic [TAGW-1:0] cand [NREQ];

  // cand[gi] is the requester examined at search position gi
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [TAGW:0] sum;
      assign sum = {1'b0, last_grant_i} + (TAGW+1)'(gi + 1);
      assign cand[gi] = (sum >= (TAGW+1)'(NREQ)) ? TAGW'(sum - (TAGW+1)'(NREQ))
                                                  : sum[TAGW-1:0];
    end
  endgenerate

  always_comb begin
    any_o       = 1'b0;
    grant_idx_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_o && req_i[cand[i]]) begin
        any_o       = 1'b1;
        grant_idx_o = cand[i];
      end
    end
    grant_o = any_o ? (NREQ'(1) << grant_idx_o) : '0;
  end
endmodule

// Widening FP96 -> FP128 conversion: sign copied, inf/NaN exponent kept,
// finite exponents rebiased, fraction left-justified and zero-filled.
module fpCvt96To128
  import fp96Pkg::*;
  import fp128Pkg::*;
(
  input  fp96_t  a_i,
  output fp128_t y_o
);
  always_comb begin
    y_o.sign = a_i.sign;
    y_o.exp  = (a_i.exp == FP96_EXP_MAX) ? FP128_EXP_MAX
                                         : (a_i.exp - FP96_BIAS + FP128_BIAS);
    y_o.sig  = {a_i.sig, {(FP128_SIGW-FP96_SIGW){1'b0}}};
  end
endmodule

// File: rtl/fp_cvt96_to128_arb.sv
// Shares one FP96->FP128 converter among NREQ requesters: round-robin accept,
// one cycle to convert, then hold the tagged result until the consumer takes it.
module fp_cvt96_to128_arb
  import fp96Pkg::*;
  import fp128Pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TAGW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  fp96_t [NREQ-1:0]      req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output fp128_t                out_data,
  output logic [TAGW-1:0]       out_tag,
  output logic                  busy
);
  cvt_state_e      state_q, state_d;
  logic [TAGW-1:0] last_grant_q, last_grant_d;
  logic [TAGW-1:0] tag_q, tag_d;
  fp96_t           op_q, op_d;
  fp128_t          res_q, res_d;
  fp128_t          cvt_res;
  logic [NREQ-1:0] grant;
  logic [TAGW-1:0] grant_idx;
  logic            grant_any;

  rr_arbiter #(.NREQ(NREQ), .TAGW(TAGW)) u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .any_o        (grant_any)
  );

  fpCvt96To128 u_cvt (
    .a_i (op_q),
    .y_o (cvt_res)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    tag_d        = tag_q;
    op_d         = op_q;
    res_d        = res_q;
    req_ready    = '0;
    unique case (state_q)
      CVT_IDLE: begin
        // no grant is advertised while reset is held
        req_ready = rst ? '0 : grant;
        if (grant_any) begin
          op_d         = req_data[grant_idx];
          tag_d        = grant_idx;
          last_grant_d = grant_idx;
          state_d      = CVT_CONV;
        end
      end
      CVT_CONV: begin
        res_d   = cvt_res;
        state_d = CVT_HOLD;
      end
      CVT_HOLD: begin
        if (out_ready) state_d = CVT_IDLE;
      end
      default: state_d = CVT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CVT_IDLE;
      last_grant_q <= TAGW'(NREQ - 1);
      tag_q        <= '0;
      op_q         <= '0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tag_q        <= tag_d;
      op_q         <= op_d;
      res_q        <= res_d;
    end
  end

  assign out_valid = (state_q == CVT_HOLD);
  assign busy      = (state_q != CVT_IDLE);
  assign out_data  = res_q;
  assign out_tag   = tag_q;
endmodule

// File: tb/tb_fp_cvt96_to128_arb.sv
// Scoreboarded bench for the shared FP96->FP128 converter scheduler.
module tb_fp_cvt96_to128_arb;
  import fp96Pkg::*;
  import fp128Pkg::*;

  localparam int NREQ = 4;
  localparam int TAGW = 2;

  typedef struct {
    logic [127:0] data;
    int           tag;
    int           cyc;
  } sb_entry_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  fp96_t [NREQ-1:0]   req_data = '0;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic               out_ready = 1'b1;
  fp128_t             out_data;
  logic [TAGW-1:0]    out_tag;
  logic               busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  sb_entry_t sb[$];
  int grants[$];
  int gcyc[$];
  int n_grant [NREQ];
  logic [127:0] exp_for [NREQ];
  logic prev_ov = 1'b0;

  fp_cvt96_to128_arb #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %h (cycle %0d)", tag, got, cyc);
    end
  endtask

  function automatic logic [127:0] cvt_ref(input logic [95:0] d);
    logic [127:0] r;
    r[127]     = d[95];
    r[126:112] = d[94:80];
    r[111:32]  = d[79:0];
    r[31:0]    = '0;
    return r;
  endfunction

  // Monitor: push expectations on accept, pop and compare on result transfer
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_ov <= 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) check("unexpected_valid", 1, 0);
        else check("latency", cyc - sb[0].cyc, 2);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", {126'b0, out_tag}, 128'hDEAD);
        end else begin
          sb_entry_t e;
          e = sb.pop_front();
          check("result_data", out_data, e.data);
          check("result_tag", out_tag, e.tag);
        end
      end
      if (req_ready != 0) check("grant_onehot", $countones(req_ready), 1);
      for (int k = 0; k < NREQ; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          sb.push_back('{exp_for[k], k, cyc});
          grants.push_back(k);
          gcyc.push_back(cyc);
          n_grant[k]++;
        end
      end
      prev_ov <= out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int k, input logic [95:0] d, input logic [127:0] e);
    int waited;
    req_data[k]  = d;
    exp_for[k]   = e;
    req_valid[k] = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!req_ready[k] && waited < 40);
    if (!req_ready[k]) check("grant_timeout", {127'b0, req_ready[k]}, 1);
    step();
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || sb.size() != 0) && n < 60);
    if (busy || sb.size() != 0) check("idle_timeout", {127'b0, busy}, 0);
    step();
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    if (!out_valid) check("out_valid_timeout", {127'b0, out_valid}, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  initial begin
    logic [127:0] hd;
    logic [TAGW-1:0] ht;
    logic [95:0] d;
    int g0, n, g1;

    for (int k = 0; k < NREQ; k++) n_grant[k] = 0;
    for (int k = 0; k < NREQ; k++) exp_for[k] = '0;

    // Reset state, with every requester asserting valid
    req_valid = '1;
    repeat (3) step();
    @(negedge clk);
    check("rst_out_valid", {127'b0, out_valid}, 0);
    check("rst_req_ready", {124'b0, req_ready}, 0);
    check("rst_busy", {127'b0, busy}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", {126'b0, out_tag}, 0);
    step();
    req_valid = '0;
    rst = 1'b0;
    step();

    // Single request: 1.0 on requester 2
    req_data[2]  = {1'b0, 15'h3FFF, 80'h0};
    exp_for[2]   = {1'b0, 15'h3FFF, 112'h0};
    req_valid[2] = 1'b1;
    @(negedge clk);
    check("single_ready", {124'b0, req_ready}, 128'h4);
    step();
    req_valid[2] = 1'b0;
    wait_idle();

    // Specials, then a few random finite values
    offer(0, {1'b0, 15'h7FFF, 80'h0}, {1'b0, 15'h7FFF, 112'h0});
    offer(1, {1'b0, 15'h7FFF, 1'b1, 79'h0}, {1'b0, 15'h7FFF, 1'b1, 111'h0});
    offer(3, {1'b1, 15'h0, 80'h0}, {1'b1, 15'h0, 112'h0});
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom, $urandom};
      if (d[94:80] == 15'h7FFF) d[94:80] = 15'h4000;
      offer(i, d, cvt_ref(d));
    end
    wait_idle();

    // Fairness from reset: all valid, expect 0,1,2,3,0 every 3 cycles
    do_reset();
    for (int k = 0; k < NREQ; k++) begin
      d = {$urandom, $urandom, $urandom};
      req_data[k] = d;
      exp_for[k]  = cvt_ref(d);
    end
    g0 = grants.size();
    req_valid = '1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grants.size() < g0 + 5 && n < 40);
    step();
    req_valid = '0;
    if (grants.size() < g0 + 5) begin
      check("fair_timeout", grants.size() - g0, 5);
    end else begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("fair_order%0d", i), grants[g0+i], i % 4);
        if (i > 0) check($sformatf("fair_gap%0d", i), gcyc[g0+i] - gcyc[g0+i-1], 3);
      end
    end
    wait_idle();

    // Backpressure: hold result 10 cycles while requester 3 waits
    out_ready = 1'b0;
    d = {$urandom, $urandom, $urandom};
    offer(1, d, cvt_ref(d));
    wait_out_valid();
    hd = out_data;
    ht = out_tag;
    step();
    d = {$urandom, $urandom, $urandom};
    req_data[3] = d;
    exp_for[3]  = cvt_ref(d);
    req_valid[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_data_stable", out_data, hd);
      check("bp_tag_stable", {126'b0, out_tag}, {126'b0, ht});
      check("bp_ready_zero", {124'b0, req_ready}, 0);
      check("bp_busy", {127'b0, busy}, 1);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {124'b0, req_ready}, 0);
    @(negedge clk);
    check("bp_next_grant", {124'b0, req_ready}, 128'h8);
    step();
    req_valid[3] = 1'b0;
    wait_idle();

    // Withdrawn request: requester 1 valid only for one HOLD cycle
    out_ready = 1'b0;
    g1 = n_grant[1];
    d = {$urandom, $urandom, $urandom};
    offer(2, d, cvt_ref(d));
    wait_out_valid();
    step();
    req_data[1]  = {1'b0, 15'h1234, 80'h5};
    exp_for[1]   = '1;
    req_valid[1] = 1'b1;
    step();
    req_valid[1] = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    repeat (3) step();
    check("withdrawn_no_grant", n_grant[1], g1);

    // Reset during CONV discards the result; requester 0 then beats 3
    d = {$urandom, $urandom, $urandom};
    offer(2, d, cvt_ref(d));
    rst = 1'b1;
    d = {$urandom, $urandom, $urandom};
    req_data[0] = d;
    exp_for[0]  = cvt_ref(d);
    d = {$urandom, $urandom, $urandom};
    req_data[3] = d;
    exp_for[3]  = cvt_ref(d);
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {127'b0, out_valid}, 0);
    check("midrst_busy", {127'b0, busy}, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_winner", {124'b0, req_ready}, 128'h1);
    step();
    req_valid[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[3] && n < 20);
    check("midrst_then3", {127'b0, req_ready[3]}, 1);
    step();
    req_valid[3] = 1'b0;
    wait_idle();

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
